// File: rtl/video_shifter_gen_if.sv
// Port bundle for video_shifter_gen: pixel-rate controls, palette write port,
// framebuffer fetch path and the RGBI/sync pins.
interface video_shifter_gen_if #(
  parameter int ADDR_W = 16
);
  logic              pix_en;
  logic [1:0]        mode_in;
  logic              pal_we;
  logic [1:0]        pal_sel;
  logic [3:0]        pal_data;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [7:0]        fetch_data;
  logic              hsync;
  logic              vsync;
  logic              red;
  logic              green;
  logic              blue;
  logic              intensity;
  logic              active;
  logic              frame_start;

  modport master (
    input  pix_en, mode_in, pal_we, pal_sel, pal_data, fetch_data,
    output fetch_req, fetch_addr, hsync, vsync, red, green, blue, intensity,
           active, frame_start
  );

  modport slave (
    output pix_en, mode_in, pal_we, pal_sel, pal_data, fetch_data,
    input  fetch_req, fetch_addr, hsync, vsync, red, green, blue, intensity,
           active, frame_start
  );
endinterface

// File: rtl/video_shifter_gen.sv
// Video timing generator with linear framebuffer fetch and 1/2/4 bpp shifter.
// Define VIDEO_SHIFTER_LINE_DOUBLE_EN to show every source line twice.
module video_shifter_gen #(
  parameter int H_ACTIVE     = 256,
  parameter int H_SYNC_START = 296,
  parameter int H_SYNC_END   = 344,
  parameter int H_TOTAL      = 400,
  parameter int V_ACTIVE     = 240,
  parameter int V_SYNC_START = 262,
  parameter int V_SYNC_END   = 264,
  parameter int V_TOTAL      = 268,
  parameter int ADDR_W       = 16,
  parameter int SYNC_POL     = 0
) (
  input  logic                master_clock,
  input  logic                reset,
  video_shifter_gen_if.master bus
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HA_M1  = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_ON  = HW'(H_SYNC_START);
  localparam logic [HW-1:0] HS_OFF = HW'(H_SYNC_END);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_ON  = VW'(V_SYNC_START);
  localparam logic [VW-1:0] VS_OFF = VW'(V_SYNC_END);
  localparam logic          SYNC_ON = (SYNC_POL != 0);

  logic [HW-1:0]     h_r;
  logic [HW-1:0]     h_nxt_s;
  logic [VW-1:0]     v_r;
  logic [VW-1:0]     v_nxt_s;
  logic [VW-1:0]     tgt_v_s;
  logic [1:0]        mode_r;
  logic [1:0]        wsel_s;
  logic [2:0]        pmask_s;
  logic              wrap_s;
  logic              line_fetch_s;
  logic              byte0_s;
  logic              vis_s;
  logic              load_s;
  logic [7:0]        hold_r;
  logic [7:0]        shift_r;
  logic [7:0]        src_s;
  logic [7:0]        shift_nxt_s;
  logic [3:0]        color_s;
  logic [3:0]        pal_r [4];
  logic [ADDR_W-1:0] fetch_addr_r;
  logic [ADDR_W-1:0] next_addr_r;
  logic [ADDR_W-1:0] req_addr_s;
  logic              fetch_req_r;
  logic              frame_start_r;
  logic              hsync_r;
  logic              vsync_r;
  logic              active_r;
  logic [3:0]        rgbi_r;
`ifdef VIDEO_SHIFTER_LINE_DOUBLE_EN
  logic [ADDR_W-1:0] line_start_r;
`endif

  // Raster position after the next pixel tick
  always_comb begin
    h_nxt_s = h_r;
    v_nxt_s = v_r;
    if (h_r == H_LAST) begin
      h_nxt_s = '0;
      if (v_r == V_LAST) begin
        v_nxt_s = '0;
      end else begin
        v_nxt_s = v_r + 1'b1;
      end
    end else begin
      h_nxt_s = h_r + 1'b1;
    end
  end

  // Frame mode decode; reserved mode falls back to 1bpp
  always_comb begin
    case (mode_r)
      2'd1:    begin wsel_s = 2'd1; pmask_s = 3'd3; end
      2'd2:    begin wsel_s = 2'd2; pmask_s = 3'd1; end
      default: begin wsel_s = 2'd0; pmask_s = 3'd7; end
    endcase
  end

  // Fetch points are judged on the position being entered, so the request
  // occupies the first clock spent at that position
  always_comb begin
    if (v_nxt_s == V_LAST) begin
      tgt_v_s = '0;
    end else begin
      tgt_v_s = v_nxt_s + 1'b1;
    end
    wrap_s       = (h_nxt_s == '0) && (v_nxt_s == '0);
    line_fetch_s = (v_nxt_s < V_ACT) && (h_nxt_s < HA_M1) &&
                   ((h_nxt_s[2:0] & pmask_s) == pmask_s);
    byte0_s      = (h_nxt_s == H_LAST) && (tgt_v_s < V_ACT);
  end

  // Address of the request being raised
  always_comb begin
    req_addr_s = next_addr_r;
    if (byte0_s && (tgt_v_s == '0)) begin
      req_addr_s = '0;
`ifdef VIDEO_SHIFTER_LINE_DOUBLE_EN
    end else if (byte0_s && !v_nxt_s[0]) begin
      req_addr_s = line_start_r;
`endif
    end else begin
      req_addr_s = next_addr_r;
    end
  end

  // Pixel source: the first pixel of a byte comes straight from the holding register
  always_comb begin
    vis_s  = (h_r < H_ACT) && (v_r < V_ACT);
    load_s = vis_s && ((h_r[2:0] & pmask_s) == 3'd0);
    if (load_s) begin
      src_s = hold_r;
    end else begin
      src_s = shift_r;
    end
    case (wsel_s)
      2'd1:    begin color_s = pal_r[src_s[7:6]];       shift_nxt_s = {src_s[5:0], 2'b00}; end
      2'd2:    begin color_s = src_s[7:4];              shift_nxt_s = {src_s[3:0], 4'h0};  end
      default: begin color_s = pal_r[{1'b0, src_s[7]}]; shift_nxt_s = {src_s[6:0], 1'b0};  end
    endcase
  end

  // Raster counters, per-frame mode capture and frame-start strobe
  always_ff @(posedge master_clock) begin
    if (reset) begin
      h_r           <= '0;
      v_r           <= '0;
      mode_r        <= 2'd0;
      frame_start_r <= 1'b0;
    end else if (bus.pix_en) begin
      h_r           <= h_nxt_s;
      v_r           <= v_nxt_s;
      frame_start_r <= wrap_s;
      if (wrap_s) begin
        mode_r <= bus.mode_in;
      end else begin
        mode_r <= mode_r;
      end
    end else begin
      frame_start_r <= 1'b0;
    end
  end

  // Fetch request, address sequencing and byte capture
  always_ff @(posedge master_clock) begin
    if (reset) begin
      fetch_req_r  <= 1'b0;
      fetch_addr_r <= '0;
      next_addr_r  <= ADDR_W'(1);
      hold_r       <= 8'h00;
`ifdef VIDEO_SHIFTER_LINE_DOUBLE_EN
      line_start_r <= '0;
`endif
    end else begin
      if (fetch_req_r) begin
        hold_r <= bus.fetch_data;
      end else begin
        hold_r <= hold_r;
      end
      if (bus.pix_en && (line_fetch_s || byte0_s)) begin
        fetch_req_r  <= 1'b1;
        fetch_addr_r <= req_addr_s;
        next_addr_r  <= req_addr_s + 1'b1;
`ifdef VIDEO_SHIFTER_LINE_DOUBLE_EN
        if (byte0_s) begin
          line_start_r <= req_addr_s;
        end else begin
          line_start_r <= line_start_r;
        end
`endif
      end else begin
        fetch_req_r <= 1'b0;
      end
    end
  end

  // Shifter and registered pixel/sync outputs, one tick behind the raster
  always_ff @(posedge master_clock) begin
    if (reset) begin
      shift_r  <= 8'h00;
      active_r <= 1'b0;
      rgbi_r   <= 4'h0;
      hsync_r  <= ~SYNC_ON;
      vsync_r  <= ~SYNC_ON;
    end else if (bus.pix_en) begin
      shift_r  <= shift_nxt_s;
      active_r <= vis_s;
      rgbi_r   <= vis_s ? color_s : 4'h0;
      hsync_r  <= ((h_r >= HS_ON) && (h_r < HS_OFF)) ? SYNC_ON : ~SYNC_ON;
      if (h_r == '0) begin
        vsync_r <= ((v_r >= VS_ON) && (v_r < VS_OFF)) ? SYNC_ON : ~SYNC_ON;
      end else begin
        vsync_r <= vsync_r;
      end
    end else begin
      shift_r <= shift_r;
    end
  end

  // CPU palette writes, independent of the pixel enable
  always_ff @(posedge master_clock) begin
    if (reset) begin
      pal_r[0] <= 4'h0;
      pal_r[1] <= 4'h7;
      pal_r[2] <= 4'hE;
      pal_r[3] <= 4'hF;
    end else if (bus.pal_we) begin
      pal_r[bus.pal_sel] <= bus.pal_data;
    end else begin
      pal_r <= pal_r;
    end
  end

  assign bus.fetch_req   = fetch_req_r;
  assign bus.fetch_addr  = fetch_addr_r;
  assign bus.hsync       = hsync_r;
  assign bus.vsync       = vsync_r;
  assign bus.red         = rgbi_r[3];
  assign bus.green       = rgbi_r[2];
  assign bus.blue        = rgbi_r[1];
  assign bus.intensity   = rgbi_r[0];
  assign bus.active      = active_r;
  assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_video_shifter_gen.sv
// Randomised bench for video_shifter_gen: every clock is compared against a
// raster model computed from the pixel-tick count since reset.
module tb_video_shifter_gen;
  localparam int HT = 16, HA = 8, HSS = 10, HSE = 12;
  localparam int VT = 6, VA = 4, VSS = 4, VSE = 5, AW = 16;
  localparam int FRAME = HT * VT;

  logic       master_clock = 1'b0;
  logic       reset;
  logic [7:0] mem [256];

  video_shifter_gen_if #(.ADDR_W(AW)) bus ();

  video_shifter_gen #(
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
    .ADDR_W(AW), .SYNC_POL(0)
  ) dut (
    .master_clock(master_clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 master_clock = ~master_clock;

  // framebuffer RAM answers whatever address is presented
  assign bus.fetch_data = mem[bus.fetch_addr[7:0]];

  int checks = 0;
  int errors = 0;
  int k;
  int fm [64];
  logic [3:0] pal_m [4];
  logic e_active, e_hs, e_vs, e_fs, e_req;
  logic [3:0] e_rgbi;
  int e_addr;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int ppb_of(input int md);
    case (md)
      1:       return 4;
      2:       return 2;
      default: return 8;
    endcase
  endfunction

  // colour of pixel h on line v of frame f (frames counted from reset)
  function automatic logic [3:0] pixel(input int f, input int v, input int h);
    int ppb, bpp, n, j, val;
    logic [7:0] b;
    ppb = ppb_of(fm[f]);
    bpp = 8 / ppb;
    n   = h / ppb;
    j   = h % ppb;
    if (f == 0 && v == 0 && n == 0) b = 8'h00;
    else                            b = mem[8'(v * (HA / ppb) + n)];
    val = (int'(b) >> (8 - bpp * (j + 1))) & ((1 << bpp) - 1);
    if (bpp == 4) return 4'(val);
    return pal_m[val[1:0]];
  endfunction

  task automatic model_edge();
    int p, h, v, f, q, hc, vc, ppb, n, tgt;
    if (reset) begin
      k = 0;
      fm[0] = 0;
      pal_m[0] = 4'h0; pal_m[1] = 4'h7; pal_m[2] = 4'hE; pal_m[3] = 4'hF;
      e_active = 1'b0; e_rgbi = 4'h0; e_hs = 1'b1; e_vs = 1'b1;
      e_fs = 1'b0; e_req = 1'b0; e_addr = 0;
    end else begin
      e_fs  = 1'b0;
      e_req = 1'b0;
      if (bus.pix_en) begin
        p = k; h = p % HT; v = (p / HT) % VT; f = p / FRAME;
        e_active = (h < HA) && (v < VA);
        e_rgbi   = e_active ? pixel(f, v, h) : 4'h0;
        e_hs     = !(h >= HSS && h < HSE);
        e_vs     = !(v >= VSS && v < VSE);
        k++;
        q = k; hc = q % HT; vc = (q / HT) % VT;
        if (q % FRAME == 0) begin
          e_fs = 1'b1;
          fm[q / FRAME] = int'(bus.mode_in);
        end
        ppb = ppb_of(fm[q / FRAME]);
        n   = (hc + 1) / ppb;
        tgt = (vc + 1) % VT;
        if (vc < VA && (hc + 1) % ppb == 0 && n >= 1 && n < HA / ppb) begin
          e_req  = 1'b1;
          e_addr = vc * (HA / ppb) + n;
        end else if (hc == HT - 1 && tgt < VA) begin
          e_req  = 1'b1;
          e_addr = tgt * (HA / ppb);
        end
      end
      if (bus.pal_we) pal_m[bus.pal_sel] = bus.pal_data;
    end
  endtask

  task automatic compare_all();
    check_val("active", 32'(bus.active), 32'(e_active));
    check_val("rgbi", 32'({bus.red, bus.green, bus.blue, bus.intensity}), 32'(e_rgbi));
    check_val("hsync", 32'(bus.hsync), 32'(e_hs));
    check_val("vsync", 32'(bus.vsync), 32'(e_vs));
    check_val("frame_start", 32'(bus.frame_start), 32'(e_fs));
    check_val("fetch_req", 32'(bus.fetch_req), 32'(e_req));
    check_val("fetch_addr", 32'(bus.fetch_addr), 32'(e_addr));
  endtask

  task automatic cycle(input logic pe, input logic rst, input logic pwe,
                       input logic [1:0] psel, input logic [3:0] pdat);
    bus.pix_en   = pe;
    reset        = rst;
    bus.pal_we   = pwe;
    bus.pal_sel  = psel;
    bus.pal_data = pdat;
    @(posedge master_clock);
    model_edge();
    #1;
    compare_all();
    @(negedge master_clock);
  endtask

  // pe_mode: 0 = always on, 1 = every other clock, 2 = random
  task automatic run(input int n, input int pe_mode, input bit rand_pal);
    logic pe, pwe;
    for (int i = 0; i < n; i++) begin
      case (pe_mode)
        1:       pe = (i % 2 == 0);
        2:       pe = 1'($urandom_range(0, 1));
        default: pe = 1'b1;
      endcase
      pwe = rand_pal && ($urandom_range(0, 11) == 0);
      cycle(pe, 1'b0, pwe, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA5;
    mem[1] = 8'h1B;
    mem[2] = 8'h9C;
    bus.mode_in  = 2'd0;
    bus.pix_en   = 1'b0;
    bus.pal_we   = 1'b0;
    bus.pal_sel  = 2'd0;
    bus.pal_data = 4'h0;
    reset        = 1'b1;
    @(negedge master_clock);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 2'd0, 4'h0);

    // 1bpp with palette[1] = F
    cycle(1'b0, 1'b0, 1'b1, 2'd1, 4'hF);
    run(2 * FRAME + FRAME / 2, 0, 1'b0);

    // restore palette[1], switch to 2bpp mid-frame
    cycle(1'b0, 1'b0, 1'b1, 2'd1, 4'h7);
    bus.mode_in = 2'd1;
    run(FRAME / 2 + 2 * FRAME, 0, 1'b0);

    // 4bpp, then reserved mode, with palette churn
    bus.mode_in = 2'd2;
    run(2 * FRAME, 0, 1'b1);
    bus.mode_in = 2'd3;
    run(FRAME, 0, 1'b1);

    // stretched timing
    bus.mode_in = 2'd2;
    run(4 * FRAME, 1, 1'b0);
    bus.mode_in = 2'd1;
    run(6 * FRAME, 2, 1'b1);

    // reset in the middle of line 2
    found = 1'b0;
    for (int i = 0; i <= FRAME && !found; i++) begin
      if (k % FRAME == 2 * HT + 4) found = 1'b1;
      else cycle(1'b1, 1'b0, 1'b0, 2'd0, 4'h0);
    end
    check_val("reach_line2", 32'(found), 32'd1);
    bus.mode_in = 2'd0;
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 4'h0);
    run(2 * FRAME + 8, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
